enc_vec_scan: RTL
=================

# enc_vec_scan

Sequential multi-hot-to-binary encoder: the inverse direction of the register-file write-select decoders. It accepts an N-bit select/request vector through a valid/ready handshake and streams out the binary index of every set bit, lowest first, one index per output handshake. It is used where a register mask, such as a set of registers to spill, clear, or forward, must be turned back into register numbers for the read or write port.

## Interface
Parameters:
- N, 32, width of the input vector (power of two, ≥2)
- W, $clog2(N), width of the output index (derived; do not override)

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- in_vec  input  N  multi-hot vector; bit i means index i is requested
- out_valid  output  1  out_idx is valid
- out_ready  input  1  consumer accepts out_idx
- out_idx  output  W  binary index of the lowest remaining set bit
- out_last  output  1  out_idx is the final index of the current vector

## Operation
- State machine with two states, S_IDLE and S_SCAN. There is also a pending register pend[N-1:0] and a ready flop rdy_q.
- **S_IDLE:**
  - in_ready = rdy_q.
  - out_valid = 0.
  - On in_valid && in_ready with in_vec ≠ 0: pend ← in_vec and the state goes to S_SCAN.
  - On in_valid && in_ready with in_vec = 0: the vector is consumed and discarded. There is no output, and the state stays S_IDLE.
- **S_SCAN:**
  - in_ready = 0. in_valid is ignored.
  - out_valid = 1.
  - out_idx = index of the lowest set bit of pend.
  - out_last = 1 when pend has exactly one bit set.
  - On out_valid && out_ready: clear bit out_idx in pend. If out_last = 1, go to S_IDLE.
- Indices are emitted strictly ascending. Each set bit is emitted exactly once. There are no gaps and no duplicates.
- Outputs are combinational from pend and the state only. There is no combinational path from in_* to out_*, and none from out_ready to out_*.
- **Reset:** while reset_n = 0, the following hold, asynchronously and mid-operation included:
  - state = S_IDLE
  - pend = 0
  - rdy_q = 0
  - outputs: in_ready = 0, out_valid = 0, out_idx = 0, out_last = 0
- rdy_q sets to 1 on the first rising edge with reset_n high, and stays 1 afterwards.
- An in-flight vector is lost on reset. No partial output follows.

## Timing
- Input-accept to first out_valid: 1 cycle. The cycle after the accepting edge shows out_valid = 1.
- Throughput: one index per cycle while out_ready = 1. A vector with K set bits occupies S_SCAN for exactly K handshake cycles.
- Backpressure: while out_valid && !out_ready, out_idx, out_last and pend hold stable.
- After the out_last handshake, in_ready = 1 in the next cycle. The earliest next accept is that cycle. Back-to-back vectors with K bits each therefore take K+1 cycles.
- A zero vector costs one accept cycle. in_ready remains 1.
- out_last and out_valid assert in the same cycle as the final index. out_last is never asserted without out_valid.
- Index N-1 (MSB) and index 0 must both encode correctly. There is no wrap-around: pend only ever loses bits.

## Structure
- Package enc_pkg holds:
  - typedef enum logic {S_IDLE, S_SCAN} enc_state_t
  - localparam ENC_N_DEFAULT = 32
- Sub-module prio_enc_lsb: a combinational N→W lowest-set-bit encoder with outputs idx[W-1:0] and any. It is built hierarchically in the same structural style as the decoders (2-bit leaf, tree-combined).
- A one-hot check (pend & (pend-1)) == 0 drives out_last.
- enc_vec_scan holds the FSM, pend, rdy_q and the handshake logic.

## Test plan
- Reset: hold reset_n = 0 with in_valid = 1 and in_vec = 32'hFFFF_FFFF. Required: in_ready = 0 and out_valid = 0. After release, in_ready = 1 after the first edge, and nothing is accepted before that.
- Basic scan: in_vec = 32'h8000_0011 with out_ready = 1. Required: out_idx 0, 4, 31 on three consecutive cycles; out_last only with 31; in_ready = 1 on the next cycle.
- Backpressure: in_vec = 32'h0000_0006, out_ready low for 3 cycles then high. Required: out_idx holds 1 with out_last = 0 for 3 cycles, then 1 and 2 in turn, with out_last on 2.
- Zero and single-bit vectors: in_vec = 0, then 32'h0000_0001. Required: no out_valid for the zero vector; then out_idx = 0 with out_last = 1 for one cycle.
- Ignored input: in_vec = 32'h0000_0300, then drive in_valid with 32'hFFFF_FFFF during S_SCAN. Required: only 8 and 9 are emitted; the second vector is not consumed while in_ready = 0.
- Reset mid-scan: in_vec = 32'hFFFF_FFFF, assert reset_n low after 5 indices (0 through 4). Required: out_valid drops to 0 without waiting for an edge. After release, no further indices appear until a new vector is accepted.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and defaults for the multi-hot-to-binary scan encoder.
package enc_pkg;
  typedef enum logic {S_IDLE, S_SCAN} enc_state_t;
  localparam int ENC_N_DEFAULT = 32;
endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit encoder, built as a tree of 2-bit leaves.
module prio_enc_lsb #(
  parameter int N = 32,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);
  if (N == 2) begin : g_leaf
    assign any = |vec;
    assign idx = ~vec[0];
  end else begin : g_node
    logic [W-2:0] idx_lo, idx_hi;
    logic         any_lo, any_hi;

    prio_enc_lsb #(.N(N/2)) u_lo (
      .vec (vec[N/2-1:0]),
      .idx (idx_lo),
      .any (any_lo)
    );

    prio_enc_lsb #(.N(N/2)) u_hi (
      .vec (vec[N-1:N/2]),
      .idx (idx_hi),
      .any (any_hi)
    );

    // The lower half wins whenever it has any bit set.
    assign any = any_lo | any_hi;
    assign idx = any_lo ? {1'b0, idx_lo} : {1'b1, idx_hi};
  end
endmodule

// File: rtl/enc_vec_scan.sv
// Accepts a multi-hot vector and streams the index of each set bit, lowest first.
module enc_vec_scan
  import enc_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last
);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  enc_state_t   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         rdy_q;
  logic [W-1:0] enc_idx;
  logic         enc_any;
  logic         one_hot;
  logic         in_fire, out_fire;

  prio_enc_lsb #(.N(N)) u_enc (
    .vec (pend_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Outputs depend only on registered state, so in_* and out_ready never reach out_*.
  assign one_hot   = (pend_q & (pend_q - ONE)) == '0;
  assign in_ready  = (state_q == S_IDLE) && rdy_q;
  assign out_valid = (state_q == S_SCAN) && enc_any;
  assign out_idx   = out_valid ? enc_idx : '0;
  assign out_last  = out_valid && one_hot;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (state_q == S_IDLE) begin
      // A zero vector is consumed without leaving idle.
      if (in_fire && (in_vec != '0)) begin
        pend_d  = in_vec;
        state_d = S_SCAN;
      end
    end else if (out_fire) begin
      pend_d[enc_idx] = 1'b0;
      if (out_last) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rdy_q   <= 1'b1;
    end
  end
endmodule
